alu_op_sequencer: RTL

Command front-end for the 3-bit arithmetic unit. It accepts packed operand/opcode bytes over a valid/ready handshake and drives registered, stable operands into the arithmetic unit. After a settle interval it samples the 6-bit combinational result. Results are buffered with an error flag in a small FIFO that the top level (or a downstream serializer) drains over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_result_fifo.sv | 70 +++++++
 rtl/alu_op_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcodes and sequencer state type for the 3-bit arithmetic unit front-end.
package alu_pkg;

    localparam int OPW  = 3;
    localparam int SELW = 2;
    localparam int RESW = 6;

    localparam logic [SELW-1:0] ALU_ADD = 2'b00;
    localparam logic [SELW-1:0] ALU_SUB = 2'b01;
    localparam logic [SELW-1:0] ALU_MUL = 2'b10;
    localparam logic [SELW-1:0] ALU_DIV = 2'b11;

    localparam logic [RESW-1:0] DIV0_RESULT = 6'h3F;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO of {err, data} entries with a registered head for zero-latency reads.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [6:0]                   i_din,
    input  logic                         i_pop,
    output logic [6:0]                   o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [6:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CNTW-1:0] r_count;
    logic [6:0]      r_head;

    logic            w_pop;
    logic            w_push;
    logic [PW-1:0]   w_rd_nxt;

    assign w_pop    = i_pop && (r_count != '0);
    assign w_push   = i_push && ((r_count != FULL_CNT) || w_pop);
    assign w_rd_nxt = r_rd + PW'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Head is refreshed only when the visible entry changes, so it holds its last value when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= w_rd_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNTW'(1);
            end
            if (w_pop && (r_count > CNTW'(1))) begin
                r_head <= r_mem[w_rd_nxt];
            end else if (w_push && ((r_count == '0) || (w_pop && (r_count == CNTW'(1))))) begin
                r_head <= i_din;
            end
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end: latches operands, waits SETTLE cycles, then buffers the arithmetic result.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   cmd_byte,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic [OPW-1:0]               op_a,
    output logic [OPW-1:0]               op_b,
    output logic [SELW-1:0]              op_sel,
    input  logic [RESW-1:0]              alu_result,
    output logic [RESW-1:0]              res_data,
    output logic                         res_err,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(DEPTH+1)-1:0]   res_count
);

    localparam int CNTW = $clog2(DEPTH+1);
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [OPW-1:0]  r_op_a;
    logic [OPW-1:0]  r_op_b;
    logic [SELW-1:0] r_op_sel;
    logic            w_room;
    logic            w_accept;
    logic            w_push;
    logic            w_err;
    logic [RESW-1:0] w_data;
    logic [6:0]      w_head;

    assign w_room = (res_count < FULL_CNT);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        cmd_ready   = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = w_room;
                if (cmd_valid && w_room) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_sel <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op_a   <= cmd_byte[2:0];
                r_op_b   <= cmd_byte[5:3];
                r_op_sel <= cmd_byte[7:6];
            end
        end
    end

    // Divide by zero overrides whatever the arithmetic unit returns.
    assign w_err  = (r_op_sel == ALU_DIV) && (r_op_b == '0);
    assign w_data = w_err ? DIV0_RESULT : alu_result;

    alu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({w_err, w_data}),
        .i_pop   (res_ready),
        .o_head  (w_head),
        .o_valid (res_valid),
        .o_count (res_count)
    );

    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_sel   = r_op_sel;
    assign res_data = w_head[5:0];
    assign res_err  = w_head[6];

endmodule
